// File: rtl/ascii_case_stream.sv
// Streaming multi-lane ASCII case converter with a 2-entry skid FIFO and a
// saturating count of bytes whose value was changed by the conversion.
module ascii_case_stream #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [LANES-1:0]     in_keep,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [LANES-1:0]     out_keep,
    input  logic                 clr_count,
    output logic [CNT_W-1:0]     conv_count
);

    localparam int DW    = 8 * LANES;
    localparam int INC_W = $clog2(LANES + 1);
    localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_UPPER  = 2'b01;
    localparam logic [1:0] MODE_LOWER  = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    // Letters differ from their other case only in bit 5; non-letters never change.
    function automatic logic [7:0] convert_byte(input logic [7:0] b, input logic [1:0] m);
        logic       is_up;
        logic       is_lo;
        logic [7:0] r;
        is_up = (b >= 8'h41) && (b <= 8'h5A);
        is_lo = (b >= 8'h61) && (b <= 8'h7A);
        r     = b;
        case (m)
            MODE_PASS:   r = b;
            MODE_UPPER:  if (is_lo) r = b & 8'hDF; else r = b;
            MODE_LOWER:  if (is_up) r = b | 8'h20; else r = b;
            MODE_TOGGLE: if (is_up || is_lo) r = b ^ 8'h20; else r = b;
            default:     r = b;
        endcase
        return r;
    endfunction

    logic [1:0]       state_r, state_nx_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [DW-1:0]    head_data_r, head_data_nx_s;
    logic [LANES-1:0] head_keep_r, head_keep_nx_s;
    logic [DW-1:0]    tail_data_r, tail_data_nx_s;
    logic [LANES-1:0] tail_keep_r, tail_keep_nx_s;
    logic [CNT_W-1:0] count_r, count_nx_s;

    logic             accept_s;
    logic             pop_s;
    logic [DW-1:0]    conv_data_s;
    logic [INC_W-1:0] inc_s;
    logic [SUM_W-1:0] sum_s;

    assign accept_s = in_valid & in_ready_r;
    assign pop_s    = out_valid_r & out_ready;

    // Per-lane conversion of the incoming beat and count of modified kept lanes.
    always_comb begin
        conv_data_s = in_data;
        inc_s       = {INC_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (in_keep[i]) begin
                conv_data_s[8*i +: 8] = convert_byte(in_data[8*i +: 8], mode);
                if (conv_data_s[8*i +: 8] != in_data[8*i +: 8]) begin
                    inc_s = inc_s + INC_W'(1'b1);
                end else begin
                    inc_s = inc_s;
                end
            end else begin
                conv_data_s[8*i +: 8] = in_data[8*i +: 8];
            end
        end
    end

    // FIFO next-state and entry steering; the head always drives the outputs.
    always_comb begin
        state_nx_s     = state_r;
        head_data_nx_s = head_data_r;
        head_keep_nx_s = head_keep_r;
        tail_data_nx_s = tail_data_r;
        tail_keep_nx_s = tail_keep_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    head_data_nx_s = conv_data_s;
                    head_keep_nx_s = in_keep;
                    state_nx_s     = ST_ONE;
                end else begin
                    state_nx_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && pop_s) begin
                    head_data_nx_s = conv_data_s;
                    head_keep_nx_s = in_keep;
                    state_nx_s     = ST_ONE;
                end else if (accept_s) begin
                    tail_data_nx_s = conv_data_s;
                    tail_keep_nx_s = in_keep;
                    state_nx_s     = ST_FULL;
                end else if (pop_s) begin
                    state_nx_s = ST_EMPTY;
                end else begin
                    state_nx_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    head_data_nx_s = tail_data_r;
                    head_keep_nx_s = tail_keep_r;
                    state_nx_s     = ST_ONE;
                end else begin
                    state_nx_s = ST_FULL;
                end
            end
            default: begin
                state_nx_s = ST_EMPTY;
            end
        endcase
    end

    // Saturating accumulate; a clear discards the same cycle's increment.
    always_comb begin
        sum_s = SUM_W'(count_r) + SUM_W'(inc_s);
        if (clr_count) begin
            count_nx_s = {CNT_W{1'b0}};
        end else if (accept_s) begin
            if (sum_s > SUM_W'(CNT_MAX)) begin
                count_nx_s = CNT_MAX;
            end else begin
                count_nx_s = sum_s[CNT_W-1:0];
            end
        end else begin
            count_nx_s = count_r;
        end
    end

    // FIFO state, registered handshake flags and entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_data_r <= {DW{1'b0}};
            head_keep_r <= {LANES{1'b0}};
            tail_data_r <= {DW{1'b0}};
            tail_keep_r <= {LANES{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s != ST_FULL);
            out_valid_r <= (state_nx_s != ST_EMPTY);
            head_data_r <= head_data_nx_s;
            head_keep_r <= head_keep_nx_s;
            tail_data_r <= tail_data_nx_s;
            tail_keep_r <= tail_keep_nx_s;
        end
    end

    // Converted-byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_nx_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_data   = head_data_r;
    assign out_keep   = head_keep_r;
    assign conv_count = count_r;

endmodule

// File: tb/tb_ascii_case_stream.sv
// Randomized self-checking bench for ascii_case_stream against a queue-based model;
// a second instance with a 4-bit counter exercises saturation.
module tb_ascii_case_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_keep;
    logic        out_ready;
    logic        clr_count;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [31:0] out_data_a, out_data_b;
    logic [3:0]  out_keep_a, out_keep_b;
    logic [15:0] count_a;
    logic [3:0]  count_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];
    int          cnt_a, cnt_b;

    always #5 clk = ~clk;

    ascii_case_stream #(.LANES(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_keep(in_keep), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_keep(out_keep_a), .clr_count(clr_count), .conv_count(count_a)
    );

    ascii_case_stream #(.LANES(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_keep(in_keep), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_keep(out_keep_b), .clr_count(clr_count), .conv_count(count_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: letters by ASCII range, case change by +/-32.
    function automatic int ref_byte(input int b, input int m);
        bit up = (b >= 65) && (b <= 90);
        bit lo = (b >= 97) && (b <= 122);
        if (m == 1 && lo) return b - 32;
        if (m == 2 && up) return b + 32;
        if (m == 3 && up) return b + 32;
        if (m == 3 && lo) return b - 32;
        return b;
    endfunction

    task automatic model_edge();
        logic [31:0] conv;
        int          inc;
        bit          acc, pop;
        acc  = in_valid && (q_data.size() < 2);
        pop  = out_ready && (q_data.size() > 0);
        conv = in_data;
        inc  = 0;
        for (int i = 0; i < 4; i++) begin
            if (in_keep[i]) begin
                int b, r;
                b = int'(in_data[8*i +: 8]);
                r = ref_byte(b, int'(mode));
                conv[8*i +: 8] = r[7:0];
                if (r != b) inc++;
            end
        end
        if (pop) begin
            void'(q_data.pop_front());
            void'(q_keep.pop_front());
        end
        if (acc) begin
            q_data.push_back(conv);
            q_keep.push_back(in_keep);
        end
        if (clr_count) begin
            cnt_a = 0;
            cnt_b = 0;
        end else if (acc) begin
            cnt_a = (cnt_a + inc > 65535) ? 65535 : cnt_a + inc;
            cnt_b = (cnt_b + inc > 15) ? 15 : cnt_b + inc;
        end
    endtask

    task automatic check_outputs();
        bit ev = (q_data.size() > 0);
        check_eq("in_ready", {31'd0, in_ready_a}, {31'd0, q_data.size() < 2});
        check_eq("out_valid", {31'd0, out_valid_a}, {31'd0, ev});
        check_eq("in_ready_sat", {31'd0, in_ready_b}, {31'd0, q_data.size() < 2});
        check_eq("out_valid_sat", {31'd0, out_valid_b}, {31'd0, ev});
        if (ev) begin
            check_eq("out_data", out_data_a, q_data[0]);
            check_eq("out_keep", {28'd0, out_keep_a}, {28'd0, q_keep[0]});
            check_eq("out_data_sat", out_data_b, q_data[0]);
            check_eq("out_keep_sat", {28'd0, out_keep_b}, {28'd0, q_keep[0]});
        end
        check_eq("conv_count", {16'd0, count_a}, cnt_a);
        check_eq("conv_count_sat", {28'd0, count_b}, cnt_b);
    endtask

    // Drive one cycle from a negedge, model the edge, check at the next negedge.
    task automatic step(input bit v, input logic [1:0] m, input logic [31:0] d,
                        input logic [3:0] k, input bit ordy, input bit clr);
        in_valid  = v;
        mode      = m;
        in_data   = d;
        in_keep   = k;
        out_ready = ordy;
        clr_count = clr;
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] tbl [11];
        tbl = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B, 8'h80, 8'hC1, 8'hFF};
        if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 10)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [31:0] d;
        rst_n = 1'b0; in_valid = 1'b0; mode = 2'b00; in_data = 32'd0;
        in_keep = 4'd0; out_ready = 1'b0; clr_count = 1'b0;
        cnt_a = 0; cnt_b = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check_eq("rst_out_data", out_data_a, 32'd0);
        check_eq("rst_out_keep", {28'd0, out_keep_a}, 32'd0);
        check_eq("rst_count", {16'd0, count_a}, 32'd0);
        rst_n = 1'b1;

        // Directed conversions
        step(1'b1, 2'b01, 32'h7A615B40, 4'b1111, 1'b1, 1'b0);
        check_eq("upper_data", out_data_a, 32'h5A415B40);
        check_eq("upper_count", {16'd0, count_a}, 32'd2);
        step(1'b1, 2'b10, 32'hC15A417B, 4'b0111, 1'b1, 1'b0);
        check_eq("lower_data", out_data_a, 32'hC17A617B);
        check_eq("lower_keep", {28'd0, out_keep_a}, 32'h7);
        check_eq("lower_count", {16'd0, count_a}, 32'd4);
        step(1'b1, 2'b11, 32'h44634261, 4'b1111, 1'b1, 1'b0);
        check_eq("toggle_data", out_data_a, 32'h64436241);
        check_eq("toggle_count", {16'd0, count_a}, 32'd8);
        step(1'b0, 2'b00, 32'd0, 4'd0, 1'b1, 1'b0);

        // Stall: third beat held by source until space frees
        step(1'b1, 2'b01, 32'h61626364, 4'b1111, 1'b0, 1'b0);
        step(1'b1, 2'b10, 32'h41424344, 4'b1111, 1'b0, 1'b0);
        check_eq("full_in_ready", {31'd0, in_ready_a}, 32'd0);
        repeat (2) step(1'b1, 2'b11, 32'h20617A5B, 4'b1111, 1'b0, 1'b0);
        repeat (2) step(1'b1, 2'b11, 32'h20617A5B, 4'b1111, 1'b1, 1'b0);
        repeat (3) step(1'b0, 2'b00, 32'd0, 4'd0, 1'b1, 1'b0);

        // Saturation of the 4-bit counter and clear-wins
        step(1'b0, 2'b00, 32'd0, 4'd0, 1'b1, 1'b1);
        repeat (4) step(1'b1, 2'b01, 32'h64636261, 4'b1111, 1'b1, 1'b0);
        check_eq("sat_count", {28'd0, count_b}, 32'd15);
        check_eq("nosat_count", {16'd0, count_a}, 32'd16);
        step(1'b1, 2'b01, 32'h64636261, 4'b1111, 1'b1, 1'b1);
        check_eq("clr_wins", {16'd0, count_a}, 32'd0);
        check_eq("clr_wins_sat", {28'd0, count_b}, 32'd0);

        // Reset while FULL
        step(1'b1, 2'b11, 32'h61616161, 4'b1111, 1'b0, 1'b0);
        step(1'b1, 2'b11, 32'h41414141, 4'b1111, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check_eq("arst_in_ready", {31'd0, in_ready_a}, 32'd1);
        check_eq("arst_count", {16'd0, count_a}, 32'd0);
        q_data.delete(); q_keep.delete();
        cnt_a = 0; cnt_b = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 2'b00, 32'd0, 4'd0, 1'b1, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) d[8*i +: 8] = pick_byte();
            step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), d,
                 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 40) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascii_case_stream.md
Name: ascii_case_stream

Overview:
- Streaming, multi-lane ASCII case converter; sequential successor to the 8-bit combinational uppercase block.
- Accepts LANES bytes per beat over a valid/ready handshake and applies a per-beat mode: pass, upper, lower or toggle.
- Buffers beats in a 2-entry skid FIFO so in_ready is registered, and counts the bytes it modified.
- Sits between a byte-stream source (UART RX / text buffer) and downstream consumers.

Parameters:
- LANES, 4, bytes per beat (>=1); data width = 8*LANES.
- CNT_W, 16, width of the converted-byte counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  2  per-beat conversion mode, sampled with in_data: 00 pass, 01 upper, 10 lower, 11 toggle.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat; registered.
- in_data  in  8*LANES  input bytes; lane i = bits [8i+7:8i].
- in_keep  in  LANES  per-lane byte enable.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8*LANES  converted bytes.
- out_keep  out  LANES  keep, carried with its beat.
- clr_count  in  1  synchronous clear of conv_count.
- conv_count  out  CNT_W  saturating count of modified bytes.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO state EMPTY; in_ready=1; out_valid=0; out_data=0; out_keep=0; conv_count=0.
  - Reset mid-transfer drops all buffered beats.
- Handshake:
  - Input accepted when in_valid & in_ready; output transfers when out_valid & out_ready.
  - out_data and out_keep are held stable while out_valid=1 and out_ready=0.
- Per-byte conversion, applied at acceptance; converted data is stored:
  - Upper letter = 0x41..0x5A; lower letter = 0x61..0x7A.
  - upper mode: clear bit5 of lower letters only.
  - lower mode: set bit5 of upper letters only.
  - toggle mode: flip bit5 of any letter.
  - pass mode: no change.
  - All other bytes, including 0x80..0xFF, '@' 0x40, '[' 0x5B, '`' 0x60 and '{' 0x7B, are always unchanged.
  - Lanes with keep=0 pass unchanged and are never counted.
- FIFO FSM (2 entries, head drives outputs):
  - EMPTY: accept -> ONE.
  - ONE: accept & !pop -> FULL; pop & !accept -> EMPTY; accept & pop -> ONE, new beat becomes head next cycle.
  - FULL: pop -> ONE, second entry becomes head; no accept because in_ready=0.
  - in_ready = (state != FULL), registered.
  - out_valid = (state != EMPTY).
- Latency: beat accepted at edge N is visible on out_* after edge N, provided the FIFO was EMPTY or the head popped at N.
- Throughput: 1 beat/cycle sustained when out_ready=1 continuously.
- Beat order is strictly preserved.
- Counter:
  - On each accepted beat, conv_count += number of kept lanes whose byte changed (0..LANES).
  - Saturates at 2^CNT_W-1; never wraps.
  - clr_count=1 sets conv_count to 0 and discards that cycle's increment (clear wins).
- mode is not latched between beats; each beat uses the mode present at its acceptance.

Test Plan:
- Reset then mode=01, in_data=0x7A_61_5B_40, keep=1111, out_ready=1 -> next cycle out_data=0x5A_41_5B_40, conv_count=2, in_ready stays 1.
- mode=10, in_data=0xC1_5A_41_7B, keep=0111 -> out_data=0xC1_7A_61_7B, out_keep=0111, conv_count increments by 2; the 0xC1 lane is masked and unconverted.
- mode=11, "aBcD" = 0x44_63_42_61, keep=1111 -> out_data=0x64_43_62_41; conv_count+4.
- out_ready=0, push 3 beats back-to-back -> beats 1-2 accepted, in_ready=0 from cycle after 2nd accept, beat 3 held by source; raise out_ready -> outputs appear in order beat1, beat2, beat3 with no data change while stalled.
- CNT_W=4, stream 4 beats of 4 convertible bytes -> conv_count saturates at 15; assert clr_count together with an accepted convertible beat -> conv_count=0.
- Two beats buffered (FULL), drop rst_n mid-cycle -> immediately out_valid=0, in_ready=1, conv_count=0; after release no stale beat emerges.
